// File: rtl/rst_seq_pkg.sv
// Shared types and default constants for the RISC-Y reset sequencer.
// Optional watchdog is selected by RST_SEQ_WDT_EN in rst_seq.sv.
package rst_seq_pkg;

    localparam int DEF_ADDR_W    = 5;
    localparam int DEF_STAGE_GAP = 4;
    localparam int DEF_WDT_W     = 16;
    localparam int SYNC_STAGES   = 2;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        MEM_REL,
        RUN
    } state_e;

endpackage

// File: rtl/rst_sync.sv
// Async-assert / sync-deassert reset synchronizer.
// Its output srst_no drops together with rst_ni and rises on the SYNC_STAGES-th clock edge after release.
module rst_sync
    import rst_seq_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    output logic srst_no
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign srst_no = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronized reset, register-file clear walk, staged memory/core release and warm reset.
// Define RST_SEQ_WDT_EN to build in the watchdog that forces a warm reset when it is not serviced.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int STAGE_GAP = DEF_STAGE_GAP,
    parameter int WDT_W     = DEF_WDT_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              soft_rst_req,
    input  logic              wdt_kick,
    output logic              mem_rst_n,
    output logic              core_rst_n,
    output logic              clr_en,
    output logic [ADDR_W-1:0] clr_addr,
    output logic              ready,
    output logic              wdt_flag
);

    localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(STAGE_GAP - 1);

    logic srst_n;

    rst_sync u_rst_sync (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .srst_no (srst_n)
    );

    state_e             state_q;
    logic [ADDR_W-1:0]  clr_addr_q;
    logic [GAP_W-1:0]   gap_q;
    logic               mem_rst_n_q;
    logic               core_rst_n_q;
    logic               clr_en_q;
    logic               ready_q;
    logic               wdt_fire_d;
    logic               warm_d;

`ifdef RST_SEQ_WDT_EN
    logic [WDT_W-1:0] wdt_q;
    logic             wdt_flag_q;

    // A kick on the terminal count still counts as service, so it suppresses the timeout.
    assign wdt_fire_d = (state_q == RUN) && !wdt_kick && (wdt_q == '1);

    always_ff @(posedge CLK or negedge srst_n) begin
        if (!srst_n) begin
            wdt_q      <= '0;
            wdt_flag_q <= 1'b0;
        end else begin
            if ((state_q != RUN) || wdt_kick || wdt_fire_d) begin
                wdt_q <= '0;
            end else begin
                wdt_q <= wdt_q + 1'b1;
            end
            if (wdt_fire_d) begin
                wdt_flag_q <= 1'b1;
            end
        end
    end

    assign wdt_flag = wdt_flag_q;
`else
    logic [WDT_W-1:0] unused_wdt;

    assign unused_wdt = {WDT_W{wdt_kick}};
    assign wdt_fire_d = 1'b0;
    assign wdt_flag   = 1'b0;
`endif

    assign warm_d = soft_rst_req || wdt_fire_d;

    always_ff @(posedge CLK or negedge srst_n) begin
        if (!srst_n) begin
            state_q      <= IDLE;
            clr_addr_q   <= '0;
            gap_q        <= '0;
            mem_rst_n_q  <= 1'b0;
            core_rst_n_q <= 1'b0;
            clr_en_q     <= 1'b0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q    <= CLEAR;
                    clr_en_q   <= 1'b1;
                    clr_addr_q <= '0;
                end
                CLEAR: begin
                    if (clr_addr_q == '1) begin
                        state_q     <= MEM_REL;
                        clr_en_q    <= 1'b0;
                        clr_addr_q  <= '0;
                        mem_rst_n_q <= 1'b1;
                        gap_q       <= '0;
                    end else begin
                        clr_addr_q <= clr_addr_q + 1'b1;
                    end
                end
                MEM_REL: begin
                    if (gap_q == GAP_LAST) begin
                        state_q      <= RUN;
                        core_rst_n_q <= 1'b1;
                        ready_q      <= 1'b1;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                RUN: begin
                    // Warm reset re-enters CLEAR directly; IDLE is reserved for the hard reset.
                    if (warm_d) begin
                        state_q      <= CLEAR;
                        mem_rst_n_q  <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        ready_q      <= 1'b0;
                        clr_en_q     <= 1'b1;
                        clr_addr_q   <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_rst_n  = mem_rst_n_q;
    assign core_rst_n = core_rst_n_q;
    assign clr_en     = clr_en_q;
    assign clr_addr   = clr_addr_q;
    assign ready      = ready_q;

endmodule

// File: tb/tb_rst_seq.sv
// Scoreboard bench for rst_seq: a position-in-sequence model predicts every output vector per edge.
// Watchdog scenarios are compiled in when RST_SEQ_WDT_EN is defined.
module tb_rst_seq;

    localparam int ADDR_W    = 5;
    localparam int STAGE_GAP = 4;
`ifdef RST_SEQ_WDT_EN
    localparam int WDT_W  = 4;
    localparam bit WDT_EN = 1'b1;
`else
    localparam int WDT_W  = 16;
    localparam bit WDT_EN = 1'b0;
`endif
    localparam int N       = 1 << ADDR_W;
    localparam int G       = STAGE_GAP;
    localparam int WDT_LIM = 1 << WDT_W;
    localparam int VW      = ADDR_W + 5;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              soft_rst_req = 1'b0;
    logic              wdt_kick = 1'b0;
    logic              mem_rst_n;
    logic              core_rst_n;
    logic              clr_en;
    logic [ADDR_W-1:0] clr_addr;
    logic              ready;
    logic              wdt_flag;

    rst_seq #(
        .ADDR_W    (ADDR_W),
        .STAGE_GAP (STAGE_GAP),
        .WDT_W     (WDT_W)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .soft_rst_req (soft_rst_req),
        .wdt_kick     (wdt_kick),
        .mem_rst_n    (mem_rst_n),
        .core_rst_n   (core_rst_n),
        .clr_en       (clr_en),
        .clr_addr     (clr_addr),
        .ready        (ready),
        .wdt_flag     (wdt_flag)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int            e;
        logic [VW-1:0] v;
    } exp_t;

    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;
    string phase = "reset";

    // Reference state: pos = edges since the clear walk started (negative before it starts).
    int pos          = -3;
    int cyc          = 0;
    int last_service = 0;
    bit flag_m       = 1'b0;

    function automatic logic [VW-1:0] expect_vec(input int p, input bit f);
        logic              m, c, e, r;
        logic [ADDR_W-1:0] a;
        m = 1'b0; c = 1'b0; e = 1'b0; r = 1'b0; a = '0;
        if (p >= 0 && p < N) begin
            e = 1'b1;
            a = p[ADDR_W-1:0];
        end else if (p >= N && p < N + G) begin
            m = 1'b1;
        end else if (p >= N + G) begin
            m = 1'b1; c = 1'b1; r = 1'b1;
        end
        return {m, c, e, a, r, f};
    endfunction

    // Model: predicts the outputs after each edge (or after an asynchronous reset) and queues them.
    initial forever begin
        @(posedge CLK or negedge RST);
        if (!RST) begin
            pos    = -3;
            flag_m = 1'b0;
        end else begin
            bit in_run, fire;
            cyc++;
            in_run = (pos >= N + G);
            fire   = WDT_EN && in_run && !wdt_kick && ((cyc - last_service) == WDT_LIM);
            if (in_run && (soft_rst_req || fire)) pos = 0;
            else if (pos < N + G) pos++;
            if (fire) flag_m = 1'b1;
            if (in_run && wdt_kick) last_service = cyc;
            else if (!in_run && pos == N + G) last_service = cyc;
        end
        exp_q.push_back('{cyc, expect_vec(pos, flag_m)});
    end

    // Monitor: compares every queued prediction against the live outputs.
    initial forever begin
        @(negedge CLK or negedge RST);
        #1;
        while (exp_q.size() > 0) begin
            exp_t          x;
            logic [VW-1:0] got;
            x   = exp_q.pop_front();
            got = {mem_rst_n, core_rst_n, clr_en, clr_addr, ready, wdt_flag};
            total++;
            if (got !== x.v) begin
                bad++;
                $display("FAIL %s edge=%0d got=%h want=%h (mem,core,clr_en,addr,ready,flag)",
                         phase, x.e, got, x.v);
            end
        end
    end

    task automatic step(input bit sr, input bit kick);
        @(negedge CLK);
        #2;
        soft_rst_req = sr;
        wdt_kick     = kick;
    endtask

    task automatic set_rst(input bit v);
        @(negedge CLK);
        #2;
        RST          = v;
        soft_rst_req = 1'b0;
        wdt_kick     = 1'b0;
    endtask

    task automatic wait_run();
        int lim;
        lim = 200;
        while (pos < N + G && lim > 0) begin
            step(1'b0, 1'b0);
            lim--;
        end
        total++;
        if (lim == 0) begin
            bad++;
            $display("FAIL wait_run %s pos=%0d want>=%0d", phase, pos, N + G);
        end
    endtask

    task automatic cold_start();
        set_rst(1'b0);
        repeat ($urandom_range(1, 3)) step(1'b0, 1'b0);
        set_rst(1'b1);
    endtask

    initial begin
        #1 RST = 1'b0;

        phase = "cold";
        $display("scenario %s", phase);
        repeat (3) step(1'b0, 1'b0);
        set_rst(1'b1);
        wait_run();
        repeat (8) step(1'b0, 1'b0);

        phase = "mid_clear";
        $display("scenario %s", phase);
        cold_start();
        repeat (12) step(1'b0, 1'b0);
        set_rst(1'b0);
        repeat (2) step(1'b0, 1'b0);
        set_rst(1'b1);
        wait_run();
        repeat (4) step(1'b0, 1'b0);

        phase = "warm";
        $display("scenario %s", phase);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        wait_run();
        repeat (5) step(1'b0, 1'b0);

        phase = "ignored";
        $display("scenario %s", phase);
        cold_start();
        repeat (7) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        for (int i = 0; i < 100 && pos < N; i++) step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        wait_run();
        repeat (4) step(1'b0, 1'b0);

        phase = "priority";
        $display("scenario %s", phase);
        step(1'b1, 1'b1);
        step(1'b0, 1'b0);
        wait_run();
        repeat (4) step(1'b0, 1'b0);

`ifdef RST_SEQ_WDT_EN
        phase = "wdt_timeout";
        $display("scenario %s", phase);
        repeat (40) step(1'b0, 1'b0);
        wait_run();

        phase = "wdt_kicked";
        $display("scenario %s", phase);
        for (int i = 0; i < 6; i++) begin
            repeat (9) step(1'b0, 1'b0);
            step(1'b0, 1'b1);
        end

        phase = "wdt_flag_clear";
        $display("scenario %s", phase);
        cold_start();
        wait_run();
`endif

        phase = "random";
        $display("scenario %s", phase);
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 249) == 0) begin
                cold_start();
            end else begin
                step($urandom_range(0, 29) == 0, $urandom_range(0, 11) == 0);
            end
        end

        repeat (3) step(1'b0, 1'b0);
        @(negedge CLK);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
# rst_seq

Reset sequencer for the RISC-Y core. It takes the raw asynchronous board reset and produces an asynchronously asserted, synchronously released internal reset. It then walks the register-file clear sequence and releases memory, then core, in a fixed staged order. It also accepts a software-requested warm reset and, optionally, a watchdog.

## Interface
- ADDR_W, 5: register-file address width; clear walks 2^ADDR_W entries.
- STAGE_GAP, 4: cycles between memory release and core release (must be ≥1).
- WDT_W, 16: watchdog counter width.
- CLK  input  1  system clock.
- RST  input  1  reset, asynchronous, active-low.
- soft_rst_req  input  1  warm-reset request pulse from core; honoured only in RUN.
- wdt_kick  input  1  watchdog service pulse; ignored when watchdog compiled out.
- mem_rst_n  output  1  memory reset, active-low.
- core_rst_n  output  1  core (PC, pipeline) reset, active-low.
- clr_en  output  1  register-file clear write enable.
- clr_addr  output  ADDR_W  register-file clear address.
- ready  output  1  high only in RUN.
- wdt_flag  output  1  sticky: a watchdog timeout occurred since last RST.

## Operation
- Internal reset srst_n comes from a two-flop synchronizer: it asserts asynchronously with RST low and deasserts on the 2nd CLK rising edge after RST rises.
- All state flops are reset asynchronously by srst_n.
- Reset values: mem_rst_n=0, core_rst_n=0, clr_en=0, clr_addr=0, ready=0, wdt_flag=0, state=IDLE.
- All outputs are registered.
- FSM states: IDLE, CLEAR, MEM_REL, RUN.
  - IDLE: entered only via reset. Moves to CLEAR on the first edge with srst_n high, setting clr_en=1 and clr_addr=0.
  - CLEAR: clr_addr increments each edge. On the edge where clr_addr = 2^ADDR_W−1, it moves to MEM_REL: clr_en=0, clr_addr=0, mem_rst_n=1, gap counter=0.
  - MEM_REL: the gap counter increments each edge. On the edge where the counter = STAGE_GAP−1, it moves to RUN: core_rst_n=1, ready=1.
  - RUN: soft_rst_req=1 at an edge performs a warm reset. At that edge mem_rst_n=0, core_rst_n=0, ready=0, clr_en=1, clr_addr=0, and the state moves to CLEAR. The full CLEAR and MEM_REL sequence then repeats.
- soft_rst_req in IDLE, CLEAR or MEM_REL is ignored; it is not queued.
- RST low at any point aborts the sequence immediately. All outputs take their reset values asynchronously. The sequence restarts from IDLE.
- clr_addr wraps only by the CLEAR→MEM_REL transition; it never counts past 2^ADDR_W−1.

## Timing
- Edges are numbered from the first rising edge after RST rises (edge 0).
- srst_n high after edge 1. clr_en high after edge 2 with clr_addr=0.
- clr_addr=k after edge 2+k.
- mem_rst_n high after edge 2+2^ADDR_W.
- core_rst_n and ready high after edge 2+2^ADDR_W+STAGE_GAP.
- Warm reset: outputs drop one edge after soft_rst_req is sampled. Re-release follows 2^ADDR_W+STAGE_GAP edges later.
- Simultaneous soft_rst_req and wdt_kick in RUN: the warm reset wins.

## Configuration
- RST_SEQ_WDT_EN defined: a WDT_W-bit counter runs only in RUN.
  - It clears on RUN entry and on wdt_kick.
  - When it reaches 2^WDT_W−1 with no kick, the next edge performs a warm reset exactly as soft_rst_req does and sets wdt_flag.
  - wdt_flag clears only on RST.
- RST_SEQ_WDT_EN undefined: no counter exists, wdt_kick is unused, and wdt_flag is tied 0.

## Structure
- Package rst_seq_pkg holds the state enum (IDLE, CLEAR, MEM_REL, RUN) and default constants for ADDR_W, STAGE_GAP and WDT_W.
- Sub-module rst_sync is the two-flop async-assert/sync-deassert synchronizer producing srst_n. It is instantiated once.
- The FSM, counters and watchdog live in rst_seq.

## Test plan
- Cold reset (defaults): RST low then high.
  - clr_en rises after edge 2; clr_addr runs 0..31 on edges 2..33.
  - mem_rst_n rises after edge 34; core_rst_n and ready rise after edge 38.
- Reset mid-clear: drop RST at clr_addr=10.
  - All outputs go to 0 with no CLK edge.
  - After release, the sequence restarts with clr_en after edge 2.
- Warm reset: 1-cycle soft_rst_req in RUN.
  - Next edge: core_rst_n=0, mem_rst_n=0, ready=0, clr_en=1, clr_addr=0.
  - ready returns 36 edges later.
- Ignored request: soft_rst_req pulsed during CLEAR (clr_addr=5) and during MEM_REL.
  - Timing is identical to a cold reset; no extra clear pass.
- Watchdog (RST_SEQ_WDT_EN, WDT_W=4): no kicks in RUN.
  - Warm reset 16 edges after RUN entry and wdt_flag=1.
  - Kicking every 10 cycles prevents the reset.
  - wdt_flag stays 1 through the warm reset and clears only on RST.
- Priority: soft_rst_req and wdt_kick together in RUN cause a warm reset.
